// File: rtl/fila_pkg.sv
// Shared types for the elevator request queue: FSM state encoding, default floor width, stop entry.
package fila_pkg;

    localparam int ANDAR_W_PADRAO = 2;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        GRAVA_ORIGEM  = 2'd1,
        GRAVA_DESTINO = 2'd2,
        REJEITA       = 2'd3
    } estado_t;

    typedef struct packed {
        logic                      eh_origem;
        logic [ANDAR_W_PADRAO-1:0] andar;
    } parada_t;

endpackage

// File: rtl/fila_circular.sv
// Generic synchronous circular FIFO with write, pop, flush and occupancy count.
module fila_circular #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_dado_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] cabeca_o,
    output logic [PTR_W:0]    count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic              wr_ok, pop_ok;

    assign wr_ok  = wr_en_i && !flush_i;
    assign pop_ok = pop_i && (count_q != '0) && !flush_i;

    // A simultaneous write and pop leaves the occupancy unchanged.
    always_comb begin
        count_d = count_q;
        if (wr_ok && !pop_ok)
            count_d = count_q + 1'b1;
        else if (!wr_ok && pop_ok)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok)
            mem_q[wr_ptr_q] <= wr_dado_i;
    end

    assign cabeca_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;

endmodule

// File: rtl/fila_pedidos.sv
// Request queue for uc_movimento: splits (origem, destino) requests into two stop entries.
// Optional FILA_OCUPACAO_DB_EN exposes the queue occupancy on ocupacao_db.
module fila_pedidos
    import fila_pkg::*;
#(
    parameter int ANDAR_W = ANDAR_W_PADRAO,
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clearSuperRam,
    input  logic               novo_pedido,
    input  logic [ANDAR_W-1:0] origem,
    input  logic [ANDAR_W-1:0] destino,
    input  logic [ANDAR_W-1:0] andar_atual,
    input  logic               shift,
    output logic               temDestino,
    output logic [ANDAR_W-1:0] destino_atual,
    output logic               eh_origem,
    output logic               sobe,
    output logic               chegouDestino,
    output logic               pedido_aceito,
    output logic               pedido_rejeitado,
    output logic               fila_cheia,
`ifdef FILA_OCUPACAO_DB_EN
    output logic [PTR_W:0]     ocupacao_db,
`endif
    output logic [3:0]         estado_db
);

    localparam int ENT_W = ANDAR_W + 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LIMITE_CHEIA = CNT_W'(DEPTH - 2);

    estado_t            estado_q;
    logic [ANDAR_W-1:0] origem_q, destino_q;
    logic               aceito_q, rejeitado_q;
    logic               wr_en, vazia, cheia;
    logic [ENT_W-1:0]   wr_dado, cabeca;
    logic [CNT_W-1:0]   count;

    assign cheia   = count > LIMITE_CHEIA;
    assign wr_en   = !clearSuperRam && (estado_q == GRAVA_ORIGEM || estado_q == GRAVA_DESTINO);
    assign wr_dado = (estado_q == GRAVA_ORIGEM) ? {1'b1, origem_q} : {1'b0, destino_q};

    fila_circular #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fila (
        .clock     (clock),
        .reset     (reset),
        .flush_i   (clearSuperRam),
        .wr_en_i   (wr_en),
        .wr_dado_i (wr_dado),
        .pop_i     (shift),
        .cabeca_o  (cabeca),
        .count_o   (count)
    );

    // Free space is checked once here; later pops only add room for the two writes.
    always_ff @(posedge clock) begin
        if (reset || clearSuperRam) begin
            estado_q    <= OCIOSO;
            aceito_q    <= 1'b0;
            rejeitado_q <= 1'b0;
        end else begin
            aceito_q    <= 1'b0;
            rejeitado_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (novo_pedido) begin
                        if (origem == destino || cheia) begin
                            estado_q    <= REJEITA;
                            rejeitado_q <= 1'b1;
                        end else begin
                            estado_q <= GRAVA_ORIGEM;
                        end
                    end
                end
                GRAVA_ORIGEM: begin
                    estado_q <= GRAVA_DESTINO;
                    aceito_q <= 1'b1;
                end
                GRAVA_DESTINO: estado_q <= OCIOSO;
                REJEITA:       estado_q <= OCIOSO;
                default:       estado_q <= OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (estado_q == OCIOSO && novo_pedido) begin
            origem_q  <= origem;
            destino_q <= destino;
        end
    end

    assign vazia            = (count == '0);
    assign temDestino       = !vazia;
    assign destino_atual    = vazia ? '0 : cabeca[ANDAR_W-1:0];
    assign eh_origem        = !vazia && cabeca[ANDAR_W];
    assign sobe             = destino_atual > andar_atual;
    assign chegouDestino    = !vazia && (destino_atual == andar_atual);
    assign pedido_aceito    = aceito_q;
    assign pedido_rejeitado = rejeitado_q;
    assign fila_cheia       = cheia;
    assign estado_db        = {2'b00, estado_q};
`ifdef FILA_OCUPACAO_DB_EN
    assign ocupacao_db      = count;
`endif

endmodule

// File: tb/tb_fila_pedidos.sv
// Bench for fila_pedidos: directed vector table followed by random traffic against a queue model.
module tb_fila_pedidos;

    logic       clock = 1'b0;
    logic       reset, clearSuperRam, novo_pedido, shift;
    logic [1:0] origem, destino, andar_atual, destino_atual;
    logic       temDestino, eh_origem, sobe, chegouDestino;
    logic       pedido_aceito, pedido_rejeitado, fila_cheia;
    logic [3:0] estado_db;
`ifdef FILA_OCUPACAO_DB_EN
    logic [3:0] ocupacao_db;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fila_pedidos dut (
        .clock            (clock),
        .reset            (reset),
        .clearSuperRam    (clearSuperRam),
        .novo_pedido      (novo_pedido),
        .origem           (origem),
        .destino          (destino),
        .andar_atual      (andar_atual),
        .shift            (shift),
        .temDestino       (temDestino),
        .destino_atual    (destino_atual),
        .eh_origem        (eh_origem),
        .sobe             (sobe),
        .chegouDestino    (chegouDestino),
        .pedido_aceito    (pedido_aceito),
        .pedido_rejeitado (pedido_rejeitado),
        .fila_cheia       (fila_cheia),
`ifdef FILA_OCUPACAO_DB_EN
        .ocupacao_db      (ocupacao_db),
`endif
        .estado_db        (estado_db)
    );

    // Reference model: stored stops, stops still to be written, and whether a reject pulse is due.
    int q[$];
    int pend[$];
    bit rej_m;

    function automatic logic [12:0] modelo_esp(input logic [1:0] an);
        logic       tem;
        int         e;
        logic [1:0] dst;
        logic [3:0] est;
        tem = q.size() > 0;
        e   = tem ? q[0] : 0;
        dst = e[1:0];
        if (pend.size() == 2)      est = 4'd1;
        else if (pend.size() == 1) est = 4'd2;
        else if (rej_m)            est = 4'd3;
        else                       est = 4'd0;
        return {pend.size() == 1, rej_m, tem, dst, e[2], tem && (dst > an),
                tem && (dst == an), (8 - q.size()) < 2, est};
    endfunction

    task automatic modelo_upd(input bit rs, cl, nv, input int o, d, input bit sh);
        int  qs;
        int  w;
        bit  livre;
        if (rs || cl) begin
            q.delete();
            pend.delete();
            rej_m = 1'b0;
        end else begin
            qs    = q.size();
            livre = (pend.size() == 0) && !rej_m;
            if (sh && qs > 0)
                void'(q.pop_front());
            if (pend.size() > 0) begin
                w = pend.pop_front();
                q.push_back(w);
            end
            rej_m = 1'b0;
            if (nv && livre) begin
                if (o == d || (8 - qs) < 2) begin
                    rej_m = 1'b1;
                end else begin
                    pend.push_back(4 + o);
                    pend.push_back(d);
                end
            end
        end
    endtask

    // modo 0: drive only, 1: compare against esp, 2: compare against the model.
    task automatic ciclo(input bit rs, cl, nv, input int o, d, an, input bit sh,
                         input int modo, input logic [12:0] esp, input string nome);
        logic [12:0] atual;
        reset         = rs;
        clearSuperRam = cl;
        novo_pedido   = nv;
        origem        = 2'(o);
        destino       = 2'(d);
        andar_atual   = 2'(an);
        shift         = sh;
        #1;
        atual = {pedido_aceito, pedido_rejeitado, temDestino, destino_atual, eh_origem,
                 sobe, chegouDestino, fila_cheia, estado_db};
        if (modo == 2)
            esp = modelo_esp(2'(an));
        if (modo != 0) begin
            checks++;
            if (atual !== esp) begin
                errors++;
                $display("FAIL %s: outputs {ace,rej,tem,dst,eh,sobe,cheg,cheia,est} got %b required %b",
                         nome, atual, esp);
            end
        end
`ifdef FILA_OCUPACAO_DB_EN
        if (modo == 2) begin
            checks++;
            if (int'(ocupacao_db) != q.size()) begin
                errors++;
                $display("FAIL %s ocupacao: got %0d required %0d", nome, ocupacao_db, q.size());
            end
        end
`endif
        @(posedge clock);
        modelo_upd(rs, cl, nv, o, d, sh);
        @(negedge clock);
    endtask

    typedef struct {
        bit          nv, sh, cl;
        int          o, d, an;
        logic [12:0] esp;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input bit nv, input int o, d, an, input bit sh, cl,
                                input bit ace, rej, tem, input int dst, input bit eh, sb, cg, ch,
                                input int est);
        vec_t v;
        v.nv = nv; v.o = o; v.d = d; v.an = an; v.sh = sh; v.cl = cl;
        v.esp = {ace, rej, tem, dst[1:0], eh, sb, cg, ch, est[3:0]};
        return v;
    endfunction

    initial begin
        reset = 1'b1; clearSuperRam = 1'b0; novo_pedido = 1'b0; shift = 1'b0;
        origem = '0; destino = '0; andar_atual = '0;
        rej_m = 1'b0;

        // nv,o,d,an,sh,cl | ace,rej,tem,dst,eh,sobe,cheg,cheia,est
        tab.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0)); // reset state
        tab.push_back(mk(1,2,1,0,0,0, 0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 1,0,1,2,1,1,0,0,2)); // origin at head, t+2
        tab.push_back(mk(0,0,0,2,0,0, 0,0,1,2,1,0,1,0,0)); // arrived
        tab.push_back(mk(0,0,0,2,1,0, 0,0,1,2,1,0,1,0,0));
        tab.push_back(mk(0,0,0,2,0,0, 0,0,1,1,0,0,0,0,0));
        tab.push_back(mk(0,0,0,2,1,0, 0,0,1,1,0,0,0,0,0));
        tab.push_back(mk(0,0,0,2,0,0, 0,0,0,0,0,0,0,0,0)); // empty forces zeros
        tab.push_back(mk(1,3,3,0,0,0, 0,0,0,0,0,0,0,0,0)); // origem == destino
        tab.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,0,0,0,3));
        tab.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(1,0,1,0,0,0, 0,0,0,0,0,0,0,0,0)); // fill: req 1
        tab.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 1,0,1,0,1,0,1,0,2));
        tab.push_back(mk(1,1,2,0,0,0, 0,0,1,0,1,0,1,0,0)); // req 2
        tab.push_back(mk(0,0,0,0,0,0, 0,0,1,0,1,0,1,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 1,0,1,0,1,0,1,0,2));
        tab.push_back(mk(1,2,3,0,0,0, 0,0,1,0,1,0,1,0,0)); // req 3
        tab.push_back(mk(0,0,0,0,0,0, 0,0,1,0,1,0,1,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 1,0,1,0,1,0,1,0,2));
        tab.push_back(mk(1,3,0,0,0,0, 0,0,1,0,1,0,1,0,0)); // req 4, exactly 2 free
        tab.push_back(mk(0,0,0,0,0,0, 0,0,1,0,1,0,1,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 1,0,1,0,1,0,1,1,2));
        tab.push_back(mk(1,1,3,0,0,0, 0,0,1,0,1,0,1,1,0)); // req 5, full
        tab.push_back(mk(0,0,0,0,0,0, 0,1,1,0,1,0,1,1,3));
        tab.push_back(mk(0,0,0,0,1,0, 0,0,1,0,1,0,1,1,0)); // drain 8, wrap
        tab.push_back(mk(0,0,0,0,1,0, 0,0,1,1,0,1,0,1,0));
        tab.push_back(mk(0,0,0,0,1,0, 0,0,1,1,1,1,0,0,0));
        tab.push_back(mk(0,0,0,0,1,0, 0,0,1,2,0,1,0,0,0));
        tab.push_back(mk(0,0,0,0,1,0, 0,0,1,2,1,1,0,0,0));
        tab.push_back(mk(0,0,0,0,1,0, 0,0,1,3,0,1,0,0,0));
        tab.push_back(mk(0,0,0,0,1,0, 0,0,1,3,1,1,0,0,0));
        tab.push_back(mk(0,0,0,0,1,0, 0,0,1,0,0,0,1,0,0));
        tab.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(1,1,2,3,0,0, 0,0,0,0,0,0,0,0,0)); // pop during write
        tab.push_back(mk(0,0,0,3,0,0, 0,0,0,0,0,0,0,0,1));
        tab.push_back(mk(0,0,0,3,0,0, 1,0,1,1,1,0,0,0,2));
        tab.push_back(mk(1,2,0,3,0,0, 0,0,1,1,1,0,0,0,0));
        tab.push_back(mk(0,0,0,3,1,0, 0,0,1,1,1,0,0,0,1));
        tab.push_back(mk(0,0,0,3,0,0, 1,0,1,2,0,0,0,0,2));
        tab.push_back(mk(0,0,0,3,1,0, 0,0,1,2,0,0,0,0,0));
        tab.push_back(mk(0,0,0,3,1,0, 0,0,1,2,1,0,0,0,0));
        tab.push_back(mk(0,0,0,3,1,0, 0,0,1,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,3,0,0, 0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(1,0,3,0,0,0, 0,0,0,0,0,0,0,0,0)); // flush mid-write
        tab.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0,0,1));
        tab.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(1,3,2,0,0,0, 0,0,0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 1,0,1,3,1,1,0,0,2));
        tab.push_back(mk(0,0,0,0,0,0, 0,0,1,3,1,1,0,0,0));

        @(negedge clock);
        for (int i = 0; i < 3; i++)
            ciclo(1, 0, 0, 0, 0, 0, 0, 0, '0, "reset");
        for (int i = 0; i < tab.size(); i++)
            ciclo(0, tab[i].cl, tab[i].nv, tab[i].o, tab[i].d, tab[i].an, tab[i].sh,
                  1, tab[i].esp, $sformatf("vec%0d", i));

        for (int i = 0; i < 2; i++)
            ciclo(1, 0, 0, 0, 0, 0, 0, 0, '0, "reset");
        for (int i = 0; i < 3000; i++) begin
            bit rs, cl, nv, sh;
            rs = ($urandom % 500) == 0;
            cl = ($urandom % 64) == 0;
            nv = ($urandom % 3) == 0;
            sh = ((i % 1000) < 500) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            ciclo(rs, cl, nv, int'($urandom % 4), int'($urandom % 4), int'($urandom % 4), sh,
                  2, '0, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
